muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It sits beside the ALU in the execute stage and provides signed/unsigned MULT, DIV, MTHI and MTLO. It raises a stall request that the hazard unit uses to freeze F/D/E while an operation iterates, and it honours the execute-stage flush as a cancel.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO for the execute stage.
// One shift-add or restoring-divide step per cycle; results commit after WIDTH steps.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_opd;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_dbz;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz_out;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_issue;
  logic                 w_mt;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH+1:0]     w_trial;
  logic                 w_ok;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [2*WIDTH-1:0]   w_div_nxt;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_signed  = ~op[0];
  assign w_issue   = start & ~op[2] & ~cancel & (r_state != S_CALC);
  assign w_mt      = start & ~cancel & (r_state != S_CALC) & (op[2:1] == 2'b10);
  assign stall_req = w_issue | (r_state == S_CALC);

  assign w_abs_a = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial, multiplier}; add multiplicand when LSB set, then shift right.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift in next bit, keep difference if non-negative.
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial   = {1'b0, w_shift} - {2'b00, r_opd};
  assign w_ok      = ~w_trial[WIDTH+1];
  assign w_rem_nxt = w_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_ok};

  assign w_step = r_is_div ? w_div_nxt : w_mul_nxt;
  assign w_prod = r_neg_res ? -w_step : w_step;
  assign w_quo  = r_neg_res ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_CALC: begin
          if (cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_dbz_out <= r_dbz;
              // A zero divisor still iterates but leaves HI/LO untouched.
              if (!r_dbz) begin
                if (r_is_div) begin
                  r_lo <= w_quo;
                  r_hi <= w_rem;
                end else begin
                  {r_hi, r_lo} <= w_prod;
                end
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (w_issue) begin
            r_state   <= S_CALC;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= w_signed & a[WIDTH-1];
            r_dbz     <= op[1] & (b == '0);
            r_opd     <= op[1] ? w_abs_b : w_abs_a;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
          end else if (w_mt) begin
            if (op[0]) r_lo <= a;
            else       r_hi <= a;
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz_out;
  assign hi          = r_hi;
  assign lo          = r_lo;
endmodule
